cv_pad_emu: RTL and testbench

- Emulates one ColecoVision hand controller at controller-port pin level: joystick, two fire buttons, 12-key keypad and a spinner.
- Acts as the responder to the console's select outputs ctrl_p5_o (keypad select) and ctrl_p8_o (joystick select).
- Drives the per-player bit of ctrl_p1_i..ctrl_p4_i, ctrl_p6_i, ctrl_p7_i and ctrl_p9_i.
- Instantiated once per player; inputs come from a host/USB decoded pad.

---
 rtl/cv_pad_emu_if.sv | 32 +++
 rtl/cv_pad_emu.sv | 195 +++++++++++++++++++
 tb/tb_cv_pad_emu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cv_pad_emu_if.sv
// Pin-level bundle between one emulated ColecoVision hand controller and the console/host.
// The master side is the console selects plus the host pad; the slave side is the emulator.
interface cv_pad_emu_if;
  logic        sel_key_n_i;
  logic        sel_joy_n_i;
  logic [3:0]  joy_i;
  logic        fire_l_i;
  logic        fire_r_i;
  logic [11:0] key_i;
  logic [7:0]  spin_delta_i;
  logic        spin_valid_i;
  logic        p1_o;
  logic        p2_o;
  logic        p3_o;
  logic        p4_o;
  logic        p6_o;
  logic        p7_o;
  logic        p9_o;
  logic        spin_busy_o;

  modport master (
    output sel_key_n_i, sel_joy_n_i, joy_i, fire_l_i, fire_r_i, key_i,
           spin_delta_i, spin_valid_i,
    input  p1_o, p2_o, p3_o, p4_o, p6_o, p7_o, p9_o, spin_busy_o
  );

  modport slave (
    input  sel_key_n_i, sel_joy_n_i, joy_i, fire_l_i, fire_r_i, key_i,
           spin_delta_i, spin_valid_i,
    output p1_o, p2_o, p3_o, p4_o, p6_o, p7_o, p9_o, spin_busy_o
  );
endinterface

// File: rtl/cv_pad_emu.sv
// ColecoVision hand controller emulator: debounced joystick/fire/keypad muxed onto the
// data pins by the console selects, plus a spinner driving quadrature on p9/p7.
module cv_pad_emu #(
  parameter int DEBOUNCE_TICKS = 8,
  parameter int STEP_TICKS     = 64,
  parameter int ACC_MAX        = 255
) (
  input  logic        clk_i,
  input  logic        reset_n_s,
  input  logic        clk_en_i,
  cv_pad_emu_if.slave pad
);

  localparam int DB_W   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int N_IN   = 18;

  // Raw image: [3:0] joystick, [4] left fire, [5] right fire, [17:6] keypad.
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] img;

  assign raw_in = {pad.key_i, pad.fire_r_i, pad.fire_l_i, pad.joy_i};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_db
      logic            acc_bit_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk_i or negedge reset_n_s) begin
        if (!reset_n_s) begin
          acc_bit_reg <= 1'b0;
          cnt_reg     <= '0;
        end else if (clk_en_i) begin
          if (raw_in[gi] == acc_bit_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_W'(DEBOUNCE_TICKS - 1)) begin
            acc_bit_reg <= raw_in[gi];
            cnt_reg     <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign img[gi] = acc_bit_reg;
    end
  endgenerate

  logic [3:0]  joy_img;
  logic        fire_l_img;
  logic        fire_r_img;
  logic [11:0] key_img;

  assign joy_img    = img[3:0];
  assign fire_l_img = img[4];
  assign fire_r_img = img[5];
  assign key_img    = img[17:6];

  function automatic logic [3:0] key_code(input logic [3:0] idx);
    case (idx)
      4'd0:    key_code = 4'hA;
      4'd1:    key_code = 4'hD;
      4'd2:    key_code = 4'h7;
      4'd3:    key_code = 4'hC;
      4'd4:    key_code = 4'h2;
      4'd5:    key_code = 4'h3;
      4'd6:    key_code = 4'hE;
      4'd7:    key_code = 4'h5;
      4'd8:    key_code = 4'h1;
      4'd9:    key_code = 4'hB;
      4'd10:   key_code = 4'h9;
      4'd11:   key_code = 4'h6;
      default: key_code = 4'hF;
    endcase
  endfunction

  // Scan from the top so the lowest-numbered pressed key overwrites last and wins.
  logic [3:0] key_nib;
  always_comb begin
    key_nib = 4'hF;
    for (int i = 11; i >= 0; i--) begin
      if (key_img[i]) key_nib = key_code(4'(i));
    end
  end

  // Deselected modes contribute all-ones, so ANDing models the open-collector bus.
  logic [3:0] data_next;
  logic       fire_next;
  logic [3:0] data_reg;
  logic       fire_reg;

  always_comb begin
    data_next = (pad.sel_joy_n_i ? 4'hF : ~joy_img) & (pad.sel_key_n_i ? 4'hF : key_nib);
    fire_next = (pad.sel_joy_n_i ? 1'b1 : ~fire_l_img) & (pad.sel_key_n_i ? 1'b1 : ~fire_r_img);
  end

  always_ff @(posedge clk_i or negedge reset_n_s) begin
    if (!reset_n_s) begin
      data_reg <= 4'hF;
      fire_reg <= 1'b1;
    end else begin
      data_reg <= data_next;
      fire_reg <= fire_next;
    end
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_reg;
  logic signed [8:0]   acc_reg;
  logic signed [8:0]   acc_next;
  logic [1:0]          quad_reg;
  logic [STEP_W-1:0]   step_cnt_reg;
  logic                busy_reg;
  logic                step_fire;
  logic signed [10:0]  sum;

  localparam logic signed [10:0] SAT_HI = 11'(ACC_MAX);
  localparam logic signed [10:0] SAT_LO = -11'(ACC_MAX);

  assign step_fire = (state_reg == S_WAIT) && clk_en_i &&
                     (step_cnt_reg == STEP_W'(STEP_TICKS - 1)) && (acc_reg != 9'sd0);

  // Delta and the step's unit move are combined before one saturation.
  always_comb begin
    sum = {{2{acc_reg[8]}}, acc_reg};
    if (pad.spin_valid_i) sum = sum + {{3{pad.spin_delta_i[7]}}, pad.spin_delta_i};
    if (step_fire) sum = acc_reg[8] ? sum + 11'sd1 : sum - 11'sd1;
    if (sum > SAT_HI)      acc_next = SAT_HI[8:0];
    else if (sum < SAT_LO) acc_next = SAT_LO[8:0];
    else                   acc_next = sum[8:0];
  end

  // {A,B} Gray sequence: forward 11->10->00->01->11.
  function automatic logic [1:0] quad_fwd(input logic [1:0] q);
    case (q)
      2'b11:   quad_fwd = 2'b10;
      2'b10:   quad_fwd = 2'b00;
      2'b00:   quad_fwd = 2'b01;
      default: quad_fwd = 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] quad_rev(input logic [1:0] q);
    case (q)
      2'b11:   quad_rev = 2'b01;
      2'b01:   quad_rev = 2'b00;
      2'b00:   quad_rev = 2'b10;
      default: quad_rev = 2'b11;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_s) begin
    if (!reset_n_s) begin
      state_reg    <= S_IDLE;
      acc_reg      <= '0;
      quad_reg     <= 2'b11;
      step_cnt_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      busy_reg <= (acc_next != 9'sd0);
      case (state_reg)
        S_IDLE: begin
          if (acc_reg != 9'sd0) begin
            step_cnt_reg <= '0;
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (step_fire) begin
            quad_reg     <= acc_reg[8] ? quad_rev(quad_reg) : quad_fwd(quad_reg);
            step_cnt_reg <= '0;
          end else if (clk_en_i) begin
            step_cnt_reg <= step_cnt_reg + 1'b1;
          end
          // Covers both the last step and a cancelling delta; quadrature holds.
          if (acc_next == 9'sd0) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign pad.p1_o        = data_reg[0];
  assign pad.p2_o        = data_reg[1];
  assign pad.p3_o        = data_reg[2];
  assign pad.p4_o        = data_reg[3];
  assign pad.p6_o        = fire_reg;
  assign pad.p9_o        = quad_reg[1];
  assign pad.p7_o        = quad_reg[0];
  assign pad.spin_busy_o = busy_reg;

endmodule

// File: tb/tb_cv_pad_emu.sv
// Directed bench for cv_pad_emu: stimulus queues expected pin vectors (and the cycle they
// should appear); the monitor pops one entry per observed change of the output pins.
module tb_cv_pad_emu;

  logic clk_i = 1'b0;
  logic reset_n_s;
  logic clk_en_i;

  cv_pad_emu_if pad_if ();

  cv_pad_emu dut (
    .clk_i     (clk_i),
    .reset_n_s (reset_n_s),
    .clk_en_i  (clk_en_i),
    .pad       (pad_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] val;
    int         cyc;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;

  always @(posedge clk_i) cyc = cyc + 1;

  // {p4,p3,p2,p1,p6,p9,p7,spin_busy}
  logic [7:0] obs;
  assign obs = {pad_if.p4_o, pad_if.p3_o, pad_if.p2_o, pad_if.p1_o,
                pad_if.p6_o, pad_if.p9_o, pad_if.p7_o, pad_if.spin_busy_o};

  logic [7:0] prev_obs;
  bit         seen_first = 1'b0;

  always @(negedge clk_i) begin
    exp_t e;
    if (done) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        $display("FAIL %s: got no change, want %b at cycle %0d", e.name, e.val, e.cyc);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end else if (mon_en && (!seen_first || obs !== prev_obs)) begin
      seen_first = 1'b1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_change: got %b (was %b) at cycle %0d, want no change",
                 obs, prev_obs, cyc);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (obs === e.val) n_pass++;
        else $display("FAIL %s: got %b want %b", e.name, obs, e.val);
        if (e.cyc >= 0) begin
          n_checks++;
          if (cyc == e.cyc) n_pass++;
          else $display("FAIL %s_cycle: got %0d want %0d", e.name, cyc, e.cyc);
        end
      end
    end
    prev_obs = obs;
  end

  task automatic expect_at(input logic [7:0] v, input int c, input string n);
    exp_t e;
    e.val  = v;
    e.cyc  = c;
    e.name = n;
    exp_q.push_back(e);
  endtask

  // Holds clk_en for exactly one rising edge; always returns just after a falling edge.
  task automatic cyc1(input logic en);
    clk_en_i = en;
    @(negedge clk_i);
  endtask

  task automatic tick();
    repeat (3) cyc1(1'b0);
    cyc1(1'b1);
  endtask

  task automatic debounce_to_accept(output int t_acc);
    repeat (7) tick();
    repeat (3) cyc1(1'b0);
    cyc1(1'b1);
    t_acc = cyc;
  endtask

  initial begin
    int t;
    int p;
    reset_n_s             = 1'b1;
    clk_en_i              = 1'b0;
    pad_if.sel_key_n_i    = 1'b1;
    pad_if.sel_joy_n_i    = 1'b1;
    pad_if.joy_i          = 4'b0000;
    pad_if.fire_l_i       = 1'b0;
    pad_if.fire_r_i       = 1'b0;
    pad_if.key_i          = 12'h000;
    pad_if.spin_delta_i   = 8'h00;
    pad_if.spin_valid_i   = 1'b0;

    @(negedge clk_i);
    reset_n_s = 1'b0;
    #1;
    expect_at(8'hFE, -1, "reset");
    mon_en = 1'b1;
    @(negedge clk_i);
    repeat (2) cyc1(1'b0);
    reset_n_s = 1'b1;
    repeat (2) cyc1(1'b0);

    // Keypad mode, keys 6 and 7 together: key 6 (E) wins.
    pad_if.sel_key_n_i = 1'b0;
    pad_if.key_i = 12'h0C0;
    debounce_to_accept(t);
    expect_at(8'hEE, t + 1, "key67");
    repeat (4) cyc1(1'b0);

    // Key 5 alone -> 3, one clock after the accepting tick.
    pad_if.key_i = 12'h020;
    debounce_to_accept(t);
    expect_at(8'h3E, t + 1, "key5");
    repeat (4) cyc1(1'b0);

    // Joystick up + left fire accepted while still in keypad mode: no pin change yet.
    pad_if.joy_i = 4'b0001;
    pad_if.fire_l_i = 1'b1;
    repeat (8) tick();
    repeat (2) cyc1(1'b0);

    pad_if.sel_key_n_i = 1'b1;
    pad_if.sel_joy_n_i = 1'b0;
    expect_at(8'hE6, cyc + 1, "joy_up");
    repeat (3) cyc1(1'b0);

    pad_if.sel_key_n_i = 1'b0;
    expect_at(8'h26, cyc + 1, "both_sel");
    repeat (3) cyc1(1'b0);

    pad_if.sel_key_n_i = 1'b1;
    pad_if.sel_joy_n_i = 1'b1;
    expect_at(8'hFE, cyc + 1, "deselect");
    repeat (3) cyc1(1'b0);

    // Release, then a 5-tick fire glitch in joystick mode must never reach p6.
    pad_if.joy_i = 4'b0000;
    pad_if.fire_l_i = 1'b0;
    repeat (8) tick();
    pad_if.sel_joy_n_i = 1'b0;
    repeat (3) cyc1(1'b0);
    pad_if.fire_l_i = 1'b1;
    repeat (5) tick();
    pad_if.fire_l_i = 1'b0;
    repeat (10) tick();
    pad_if.sel_joy_n_i = 1'b1;
    repeat (2) cyc1(1'b0);

    // Spinner +3 with clk_en every cycle: steps 10, 00, 01, 64 ticks apart.
    pad_if.spin_delta_i = 8'd3;
    pad_if.spin_valid_i = 1'b1;
    p = cyc + 1;
    expect_at(8'hFF, p, "busy_on");
    cyc1(1'b1);
    pad_if.spin_valid_i = 1'b0;
    expect_at(8'hFD, p + 65, "step1");
    expect_at(8'hF9, p + 129, "step2");
    expect_at(8'hFA, p + 193, "step3");
    repeat (220) cyc1(1'b1);

    // +5 then -5 cancels: busy pulses, no step, quadrature holds at 01.
    pad_if.spin_delta_i = 8'd5;
    pad_if.spin_valid_i = 1'b1;
    expect_at(8'hFB, cyc + 1, "cancel_busy");
    expect_at(8'hFA, cyc + 2, "cancel_idle");
    cyc1(1'b1);
    pad_if.spin_delta_i = 8'hFB;
    cyc1(1'b1);
    pad_if.spin_valid_i = 1'b0;
    repeat (150) cyc1(1'b1);

    // 3 x +127 saturates at 255; -128 then -127 on the step cycle leaves -1.
    pad_if.spin_delta_i = 8'd127;
    pad_if.spin_valid_i = 1'b1;
    p = cyc + 1;
    expect_at(8'hFB, p, "sat_busy");
    repeat (3) cyc1(1'b1);
    pad_if.spin_valid_i = 1'b0;
    repeat (61) cyc1(1'b1);
    pad_if.spin_delta_i = 8'h80;
    pad_if.spin_valid_i = 1'b1;
    cyc1(1'b1);
    pad_if.spin_delta_i = 8'h81;
    expect_at(8'hFF, p + 65, "sat_fwd");
    cyc1(1'b1);
    pad_if.spin_valid_i = 1'b0;
    expect_at(8'hFA, p + 129, "sat_rev");
    repeat (80) cyc1(1'b1);

    repeat (5) cyc1(1'b0);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
